bscac7_gp_demux_dec: RTL
========================

// Module: bscac7_gp_demux_dec
// PURPOSE
//  Receive-side group de-multiplexer/decoder for one BSCAC7 Hex7 TSV array (1 centre + 6 outer TSVs).
//  Recovers transmitted data from TSV transitions (current XOR previous state) and undoes the encoder's
//  rotating group-mux selection, including the centre-TSV control bit.
//  Adds a 1-deep registered output with valid/ready, and flags forbidden crosstalk patterns.
//  Sits between the TSV receive flops and the downstream BSCAC7 word assembler.
// PARAMETERS
//  SEL_INIT   2'd0     group-select value after reset/resync (0..2; values 3 are illegal)
//  PREV_INIT  7'h00    assumed TSV state after reset (must match the encoder's initial TSV state)
// PORTS
//  clk            in   1  clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  tsv_rx         in   7  sampled TSV state; [0]=centre, [2g+2:2g+1]=group g (g=0..2)
//  tsv_valid      in   1  tsv_rx holds a new codeword this cycle
//  resync         in   1  sync pulse: load prev state from tsv_rx, reset select, no output
//  in_ready       out  1  decoder can accept a codeword this cycle
//  dec_data       out  6  recovered data; slot k = dec_data[2k+1:2k]
//  dec_ctrl       out  1  recovered control bit
//  dec_valid      out  1  dec_data/dec_ctrl valid
//  dec_ready      in   1  downstream accepts output
//  cw_err         out  1  sticky: forbidden transition pattern detected
//  ovf_err        out  1  sticky: tsv_valid while in_ready=0 (codeword lost)
//  err_clr        in   1  clears cw_err and ovf_err
// BEHAVIOUR
//  Reset: prev<=PREV_INIT, sel<=SEL_INIT, dec_data=0, dec_ctrl=0, dec_valid=0, cw_err=0, ovf_err=0.
//  in_ready = !dec_valid || dec_ready (combinational). Accept = tsv_valid && in_ready && !resync.
//  On accept: t = tsv_rx ^ prev; prev <= tsv_rx; dec_ctrl <= t[0];
//   for k in 0..2: dec_data[2k+1:2k] <= t[2g+2:2g+1], g = (k+sel) mod 3;
//   sel <= (sel==2) ? 0 : sel+1; dec_valid <= 1. Latency 1 clk accept->dec_valid.
//  No accept and dec_valid && dec_ready: dec_valid <= 0. Output holds while dec_valid && !dec_ready.
//  Accept and dec_ready in same cycle: new word replaces old, dec_valid stays 1 (full throughput).
//  tsv_valid && !in_ready: codeword dropped, prev/sel unchanged, ovf_err <= 1.
//  resync (priority over tsv_valid): prev <= tsv_rx, sel <= SEL_INIT, no output, errors unchanged;
//   a pending dec_valid word is kept and drained normally.
//  cw_err: on accept, set if any group has one bit rising and the other falling
//   (prev[2g+2:2g+1]^tsv_rx... i.e. prev=01->10 or 10->01). Word still decoded and delivered.
//  err_clr: clears both sticky flags; same-cycle new error wins (flag stays 1).
//  Reset asserted mid-operation: all state to reset values immediately; pending output discarded.
//  sel value 3 unreachable; if forced, treat as 0 for mapping and next sel = 1.
// TESTING
//  1 Reset, tsv_valid with tsv_rx=7'b0000011, dec_ready=1 -> next clk dec_valid=1, dec_ctrl=1,
//    dec_data=6'b000001 (sel=0, g0 t=01); sel becomes 1.
//  2 Three back-to-back words, each tsv_rx toggles only bits [2:1] from prev -> data 2'b11 appears
//    in slots 0,2,1 in turn (dec_data = 6'h03, 6'h30, 6'h0C); sel wraps 2->0.
//  3 dec_ready=0 with dec_valid=1, tsv_valid=1 -> in_ready=0, ovf_err=1, output unchanged;
//    err_clr -> ovf_err=0.
//  4 prev g1=2'b01, tsv_rx g1=2'b10 -> cw_err=1 next clk, dec_data slot for g1 = 2'b11.
//  5 resync with tsv_rx=7'h55 then valid word 7'h55 -> dec_data=0, dec_ctrl=0, sel back to SEL_INIT.
//  6 rst_n low while dec_valid=1 -> dec_valid=0 asynchronously; prev=PREV_INIT after release.

Source files
------------

// File: rtl/bscac7_gp_demux_dec_if.sv
// Receive-side bus for the BSCAC7 Hex7 group decoder: TSV codeword input
// with ready, decoded word output with valid/ready.
interface bscac7_gp_demux_dec_if;
  logic [6:0] tsv_rx;
  logic       tsv_valid;
  logic       resync;
  logic       in_ready;
  logic [5:0] dec_data;
  logic       dec_ctrl;
  logic       dec_valid;
  logic       dec_ready;

  modport master (
    output tsv_rx, tsv_valid, resync, dec_ready,
    input  in_ready, dec_data, dec_ctrl, dec_valid
  );

  modport slave (
    input  tsv_rx, tsv_valid, resync, dec_ready,
    output in_ready, dec_data, dec_ctrl, dec_valid
  );
endinterface

// File: rtl/bscac7_gp_demux_dec.sv
// BSCAC7 Hex7 receive decoder: transition decode, rotating group de-mux,
// 1-deep registered output, sticky crosstalk and overflow flags.
module bscac7_gp_demux_dec #(
  parameter logic [1:0] SEL_INIT  = 2'd0,
  parameter logic [6:0] PREV_INIT = 7'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bscac7_gp_demux_dec_if.slave     bus,
  output logic                     cw_err,
  output logic                     ovf_err,
  input  logic                     err_clr
);

  logic [6:0] prev_q;
  logic [1:0] sel_q;
  logic [5:0] data_q;
  logic       ctrl_q;
  logic       valid_q;

  logic       in_ready;
  logic       accept;
  logic       drop;
  logic [6:0] trans;
  logic [1:0] sel_eff;
  logic [1:0] sel_nxt;
  logic [5:0] data_nxt;
  logic       cw_hit;

  assign in_ready = !valid_q || bus.dec_ready;
  assign accept   = bus.tsv_valid && in_ready && !bus.resync;
  assign drop     = bus.tsv_valid && !in_ready && !bus.resync;
  assign trans    = bus.tsv_rx ^ prev_q;

  // An unreachable select of 3 maps like 0 so the rotation recovers.
  assign sel_eff = (sel_q == 2'd3) ? 2'd0 : sel_q;
  assign sel_nxt = (sel_eff == 2'd2) ? 2'd0 : sel_eff + 2'd1;

  always_comb begin
    int g;
    data_nxt = '0;
    for (int k = 0; k < 3; k++) begin
      g = k + int'(sel_eff);
      if (g >= 3) g = g - 3;
      data_nxt[2*k +: 2] = trans[2*g+1 +: 2];
    end
  end

  // Forbidden pattern: both wires of a group flip in opposite directions.
  always_comb begin
    logic [1:0] p;
    logic [1:0] n;
    cw_hit = 1'b0;
    for (int g = 0; g < 3; g++) begin
      p = prev_q[2*g+1 +: 2];
      n = bus.tsv_rx[2*g+1 +: 2];
      if ((p ^ n) == 2'b11 && (p[0] != p[1])) cw_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= PREV_INIT;
      sel_q   <= SEL_INIT;
      data_q  <= '0;
      ctrl_q  <= 1'b0;
      valid_q <= 1'b0;
      cw_err  <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (bus.resync) begin
        prev_q <= bus.tsv_rx;
        sel_q  <= SEL_INIT;
      end else if (accept) begin
        prev_q <= bus.tsv_rx;
        sel_q  <= sel_nxt;
      end

      if (accept) begin
        data_q  <= data_nxt;
        ctrl_q  <= trans[0];
        valid_q <= 1'b1;
      end else if (valid_q && bus.dec_ready) begin
        valid_q <= 1'b0;
      end

      if (accept && cw_hit) cw_err <= 1'b1;
      else if (err_clr)     cw_err <= 1'b0;

      if (drop)         ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dec_data  = data_q;
  assign bus.dec_ctrl  = ctrl_q;
  assign bus.dec_valid = valid_q;

endmodule
